// File: rtl/inv_shift_sub_unit_pkg.sv
// Shared definitions for the inverse ShiftRows/SubBytes unit.
// State encoding, column count and AES byte addressing.
package inv_shift_sub_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NUM_COLS = 4;

    // Bit offset of the LSB of byte (row, col); byte 0 sits at [127:120].
    function automatic logic [6:0] byte_off(
        input logic [1:0] row,
        input logic [1:0] col
    );
        int idx;
        idx = 4 * int'(col) + int'(row);
        return 7'(120 - 8 * idx);
    endfunction

endpackage

// File: rtl/inv_shift_sub_unit_inv_sbox.sv
// AES inverse S-box lookup, one byte in, one byte out.
// Purely combinational; the table is indexed by the input byte.
module inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] TAB [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign out_byte = TAB[in_byte];

endmodule

// File: rtl/inv_shift_sub_unit.sv
// Inverse ShiftRows + SubBytes, one output column per cycle.
// Four S-box lanes; result held until the downstream handshake.
module inv_shift_sub_unit
    import inv_shift_sub_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

    state_t       state;
    state_t       state_nx;
    logic [1:0]   col;
    logic [127:0] in_reg;
    logic [127:0] res;
    logic [31:0]  lane_in;
    logic [31:0]  lane_out;

    // Gather the shifted source bytes feeding output column col.
    always_comb begin
        lane_in = '0;
        for (int r = 0; r < 4; r++) begin
            logic [1:0] rr;
            logic [1:0] sc;
            rr = 2'(r);
            sc = col - rr;
            lane_in[8*r +: 8] = in_reg[byte_off(rr, sc) +: 8];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        inv_sbox u_sbox (
            .in_byte  (lane_in[8*g +: 8]),
            .out_byte (lane_out[8*g +: 8])
        );
    end

    // Next-state logic for the accept / compute / hold sequence.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (in_valid)        state_nx = ST_BUSY;
            ST_BUSY: if (col == LAST_COL) state_nx = ST_DONE;
            ST_DONE: if (out_ready)       state_nx = ST_IDLE;
            default:                      state_nx = ST_IDLE;
        endcase
    end

    // State, column counter, input latch and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            col    <= 2'd0;
            in_reg <= '0;
            res    <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && in_valid) begin
                in_reg <= in_state;
                col    <= 2'd0;
            end
            if (state == ST_BUSY) begin
                for (int r = 0; r < 4; r++) begin
                    res[byte_off(2'(r), col) +: 8] <= lane_out[8*r +: 8];
                end
                if (col != LAST_COL) col <= col + 2'd1;
            end
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_state = res;

endmodule

// File: tb/tb_inv_shift_sub_unit.sv
// Scoreboard bench for inv_shift_sub_unit.
// Reference inverse S-box is derived from GF(2^8) arithmetic.
module tb_inv_shift_sub_unit;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_acc = 0;
    int last_hs = 0;
    logic [127:0] sb[$];
    logic [7:0] isb_tab [256];

    inv_shift_sub_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tab();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b, s;
            b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            isb_tab[s] = 8'(x);
        end
    endtask

    // out[r][c] = InvSbox(in[r][(c - r) mod 4]); byte i = row i%4, col i/4.
    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                int si, di;
                si = 4 * ((c - r + 4) % 4) + r;
                di = 4 * c + r;
                o[127 - 8*di -: 8] = isb_tab[d[127 - 8*si -: 8]];
            end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] exp,
                        input bit keep, input bit gap_chk);
        int n;
        in_state = d;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 128'(n), 128'(0));
        end else begin
            sb.push_back(exp);
            last_acc = cyc + 1;
            if (gap_chk) chk("b2b_gap", 128'(last_acc - last_hs), 128'(1));
        end
        @(posedge clk);
        #1;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 128'(n >= 100), 128'(0));
    endtask

    task automatic send_rand(input bit keep, input bit gap_chk);
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d, model(d), keep, gap_chk);
    endtask

    // Monitor: scoreboard pops, hold stability, latency, exclusivity.
    initial begin
        logic pv, prev_ready, prev_rst;
        logic [127:0] prev_out, exp;
        pv = 1'b0; prev_ready = 1'b0; prev_rst = 1'b1; prev_out = '0;
        forever begin
            @(negedge clk);
            if (!rst) chk("valid_vs_ready", 128'(out_valid & in_ready), 128'(0));
            if (pv && !prev_ready && !prev_rst) begin
                chk("hold_valid", 128'(out_valid), 128'(1));
                chk("hold_state", out_state, prev_out);
            end
            if (out_valid && !pv)
                chk("latency", 128'(cyc - last_acc), 128'(LAT));
            if (out_valid && out_ready && !rst) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 128'(1), 128'(0));
                end else begin
                    exp = sb.pop_front();
                    chk("result", out_state, exp);
                end
                last_hs = cyc + 1;
            end
            pv = out_valid;
            prev_ready = out_ready;
            prev_rst = rst;
            prev_out = out_state;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        build_tab();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_state = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_state", out_state, 128'h0);
        rst = 1'b0;
        out_ready = 1'b1;

        send(128'h0, {16{8'h52}}, 1'b0, 1'b0);
        drain();
        send({16{8'h63}}, 128'h0, 1'b0, 1'b0);
        drain();
        send(128'h000102030405060708090a0b0c0d0e0f,
             128'h52f3a3383009d79ebf366afb8140a5d5, 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 6; i++) begin
            send_rand(1'b0, 1'b0);
            drain();
        end

        out_ready = 1'b0;
        send_rand(1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_timeout", 128'(out_valid), 128'(1));
        in_valid = 1'b1;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        repeat (10) begin
            @(negedge clk);
            chk("done_in_ready", 128'(in_ready), 128'(0));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        send_rand(1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_out_state", out_state, 128'h0);
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_pulse", 128'(out_valid), 128'(0));
        end
        @(posedge clk);
        #1;
        send_rand(1'b0, 1'b0);
        drain();

        for (int i = 0; i < 12; i++)
            send_rand(i < 11, i > 0);
        drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
